// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding selects,
// counter width and the register-match helper.
package hazard_pkg;

    localparam int unsigned CntWidth = 16;
    localparam int unsigned RegWidth = 5;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2,
        StWait  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FwdRegfile = 2'b00,
        FwdMem     = 2'b01,
        FwdWb      = 2'b10
    } fwd_e;

    // $0 is hard-wired, so it never matches anything.
    function automatic logic reg_match(input logic [RegWidth-1:0] a,
                                       input logic [RegWidth-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// Enabled up-counter with asynchronous active-high reset that holds at all-ones.
module sat_counter16
    import hazard_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    output logic [CntWidth-1:0] count_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CntWidth{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze > flush > stall arbitration, operand forwarding and
// performance counters. Define HAZARD_FORWARD_EN to enable Mem/Wb operand forwarding.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic [4:0]  rs_ex,
    input  logic [4:0]  rt_ex,
    input  logic [4:0]  rw_ex,
    input  logic [4:0]  rw_mem,
    input  logic [4:0]  rw_wb,
    input  logic        regwr_ex,
    input  logic        regwr_mem,
    input  logic        regwr_wb,
    input  logic        memtoreg_ex,
    input  logic        pc_redirect,
    input  logic        dmem_busy,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    state_e state_q, state_d;
    logic   pend_q, pend_d;
    logic   hz, do_freeze, do_flush, do_stall;
    logic   ex_hit;

    assign ex_hit = regwr_ex && ((use_rs_id && reg_match(rs_id, rw_ex)) ||
                                 (use_rt_id && reg_match(rt_id, rw_ex)));

`ifdef HAZARD_FORWARD_EN
    // Only a load in Ex cannot be forwarded in time; everything else is bypassed.
    assign hz = ex_hit && memtoreg_ex;

    always_comb begin
        fwd_a = FwdRegfile;
        fwd_b = FwdRegfile;
        if (regwr_mem && reg_match(rs_ex, rw_mem)) begin
            fwd_a = FwdMem;
        end else if (regwr_wb && reg_match(rs_ex, rw_wb)) begin
            fwd_a = FwdWb;
        end
        if (regwr_mem && reg_match(rt_ex, rw_mem)) begin
            fwd_b = FwdMem;
        end else if (regwr_wb && reg_match(rt_ex, rw_wb)) begin
            fwd_b = FwdWb;
        end
    end
`else
    logic mem_hit;
    logic unused_fwd_inputs;

    // Wb is excluded: the regfile writes in the first half-cycle and reads in the second.
    assign mem_hit = regwr_mem && ((use_rs_id && reg_match(rs_id, rw_mem)) ||
                                   (use_rt_id && reg_match(rt_id, rw_mem)));
    assign hz = ex_hit || mem_hit;

    assign fwd_a = FwdRegfile;
    assign fwd_b = FwdRegfile;
    assign unused_fwd_inputs = ^{rs_ex, rt_ex, rw_wb, regwr_wb, memtoreg_ex};
`endif

    assign do_freeze = dmem_busy;
    assign do_flush  = !dmem_busy && (pc_redirect || pend_q);
    assign do_stall  = hz && !do_flush && !do_freeze;

    assign freeze       = do_freeze;
    assign flush_if_id  = do_flush;
    assign flush_id_ex  = do_flush;
    assign flush_ex_mem = do_flush;
    assign stall_pc     = do_stall;
    assign stall_if_id  = do_stall;
    assign bubble_id_ex = do_stall;

    always_comb begin
        pend_d  = pend_q;
        state_d = StRun;
        // A redirect seen during a freeze must survive until the memory releases.
        if (dmem_busy && pc_redirect) begin
            pend_d = 1'b1;
        end else if (do_flush) begin
            pend_d = 1'b0;
        end
        if (do_freeze) begin
            state_d = StWait;
        end else if (do_flush) begin
            state_d = StFlush;
        end else if (do_stall) begin
            state_d = StStall;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign state = state_q;

    sat_counter16 u_stall_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (do_stall),
        .count_o (stall_cycles)
    );

    sat_counter16 u_flush_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (do_flush),
        .count_o (flush_events)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them. Covers both HAZARD_FORWARD_EN builds.
module tb_hazard_ctrl;

    localparam logic [1:0] ANone = 2'd0, AStall = 2'd1, AFlush = 2'd2, AFrz = 2'd3;

    typedef struct {
        logic       rst;
        logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rw_ex, rw_mem, rw_wb;
        logic       use_rs, use_rt, wr_ex, wr_mem, wr_wb, ld_ex, redir, busy;
    } vec_t;

    typedef struct packed {
        logic [1:0]  act;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fe;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_id, rt_id, rs_ex, rt_ex, rw_ex, rw_mem, rw_wb;
    logic        use_rs_id, use_rt_id, regwr_ex, regwr_mem, regwr_wb, memtoreg_ex;
    logic        pc_redirect, dmem_busy;
    logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic        freeze;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cycles, flush_events;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_valid = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .use_rs_id    (use_rs_id),
        .use_rt_id    (use_rt_id),
        .rs_ex        (rs_ex),
        .rt_ex        (rt_ex),
        .rw_ex        (rw_ex),
        .rw_mem       (rw_mem),
        .rw_wb        (rw_wb),
        .regwr_ex     (regwr_ex),
        .regwr_mem    (regwr_mem),
        .regwr_wb     (regwr_wb),
        .memtoreg_ex  (memtoreg_ex),
        .pc_redirect  (pc_redirect),
        .dmem_busy    (dmem_busy),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .freeze       (freeze),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .state        (state),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    function automatic vec_t idle();
        vec_t v;
        v.rst = 1'b0;
        v.rs_id = '0; v.rt_id = '0; v.rs_ex = '0; v.rt_ex = '0;
        v.rw_ex = '0; v.rw_mem = '0; v.rw_wb = '0;
        v.use_rs = 1'b0; v.use_rt = 1'b0; v.wr_ex = 1'b0; v.wr_mem = 1'b0; v.wr_wb = 1'b0;
        v.ld_ex = 1'b0; v.redir = 1'b0; v.busy = 1'b0;
        return v;
    endfunction

    function automatic logic [6:0] act_bits(input logic [1:0] a);
        case (a)
            AStall:  return 7'b0000111;
            AFlush:  return 7'b0111000;
            AFrz:    return 7'b1000000;
            default: return 7'b0000000;
        endcase
    endfunction

    // Apply one cycle of inputs; when chk is set, queue what the monitor must see.
    task automatic step(input vec_t v, input logic chk, input string nm, input logic [1:0] act,
                        input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fe,
                        input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00);
        exp_t e;
        rst = v.rst; rs_id = v.rs_id; rt_id = v.rt_id; rs_ex = v.rs_ex; rt_ex = v.rt_ex;
        rw_ex = v.rw_ex; rw_mem = v.rw_mem; rw_wb = v.rw_wb;
        use_rs_id = v.use_rs; use_rt_id = v.use_rt; regwr_ex = v.wr_ex; regwr_mem = v.wr_mem;
        regwr_wb = v.wr_wb; memtoreg_ex = v.ld_ex; pc_redirect = v.redir; dmem_busy = v.busy;
        if (chk) begin
            e.act = act; e.st = st; e.sc = sc; e.fe = fe; e.fa = fa; e.fb = fb;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        chk_valid = chk;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input string what, input logic [15:0] act,
                       input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, what, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL monitor: no expectation queued, got 0, expected 1");
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "actions", {9'd0, freeze, flush_if_id, flush_id_ex, flush_ex_mem,
                                    stall_pc, stall_if_id, bubble_id_ex}, {9'd0, act_bits(e.act)});
                cmp(nm, "state", {14'd0, state}, {14'd0, e.st});
                cmp(nm, "stall_cycles", stall_cycles, e.sc);
                cmp(nm, "flush_events", flush_events, e.fe);
                cmp(nm, "fwd", {12'd0, fwd_a, fwd_b}, {12'd0, e.fa, e.fb});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got 1, expected 0");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, hzv;
        v = idle();
        v.rst = 1'b1;
        step(v, 1'b0, "", ANone, 2'd0, 16'd0, 16'd0);
        step(v, 1'b1, "rst_idle", ANone, 2'd0, 16'd0, 16'd0);
        v.redir = 1'b1;
        step(v, 1'b1, "rst_comb_flush", AFlush, 2'd0, 16'd0, 16'd0);
        v.redir = 1'b0; v.busy = 1'b1;
        step(v, 1'b1, "rst_comb_freeze", AFrz, 2'd0, 16'd0, 16'd0);
        step(idle(), 1'b1, "idle", ANone, 2'd0, 16'd0, 16'd0);

`ifdef HAZARD_FORWARD_EN
        v = idle(); v.rw_ex = 5'd2; v.wr_ex = 1'b1; v.ld_ex = 1'b1; v.rs_id = 5'd2; v.use_rs = 1'b1;
        step(v, 1'b1, "load_use", AStall, 2'd0, 16'd0, 16'd0);
        step(idle(), 1'b1, "load_use_next", ANone, 2'd1, 16'd1, 16'd0);
        v.ld_ex = 1'b0;
        step(v, 1'b1, "alu_no_stall", ANone, 2'd0, 16'd1, 16'd0);
        v = idle(); v.rw_mem = 5'd5; v.rw_wb = 5'd5; v.wr_mem = 1'b1; v.wr_wb = 1'b1;
        v.rs_ex = 5'd5;
        step(v, 1'b1, "fwd_mem_wins", ANone, 2'd0, 16'd1, 16'd0, 2'b01, 2'b00);
        v.wr_mem = 1'b0;
        step(v, 1'b1, "fwd_wb", ANone, 2'd0, 16'd1, 16'd0, 2'b10, 2'b00);
        v = idle(); v.rw_mem = 5'd6; v.wr_mem = 1'b1; v.rt_ex = 5'd6; v.rs_ex = 5'd1;
        step(v, 1'b1, "fwd_b_mem", ANone, 2'd0, 16'd1, 16'd0, 2'b00, 2'b01);
        v = idle(); v.rw_mem = 5'd0; v.wr_mem = 1'b1; v.rw_wb = 5'd0; v.wr_wb = 1'b1;
        step(v, 1'b1, "fwd_r0", ANone, 2'd0, 16'd1, 16'd0, 2'b00, 2'b00);
`else
        v = idle(); v.rw_ex = 5'd3; v.wr_ex = 1'b1; v.rs_id = 5'd3; v.use_rs = 1'b1;
        v.rs_ex = 5'd3; v.rw_wb = 5'd3; v.wr_wb = 1'b1;
        step(v, 1'b1, "ex_hz", AStall, 2'd0, 16'd0, 16'd0);
        v = idle(); v.rw_mem = 5'd3; v.wr_mem = 1'b1; v.rs_id = 5'd3; v.use_rs = 1'b1;
        v.rs_ex = 5'd3;
        step(v, 1'b1, "mem_hz", AStall, 2'd1, 16'd1, 16'd0);
        v = idle(); v.rw_wb = 5'd3; v.wr_wb = 1'b1; v.rs_id = 5'd3; v.use_rs = 1'b1;
        step(v, 1'b1, "wb_no_hz", ANone, 2'd1, 16'd2, 16'd0);
        v = idle(); v.wr_ex = 1'b1; v.use_rs = 1'b1; v.use_rt = 1'b1;
        step(v, 1'b1, "r0_no_hz", ANone, 2'd0, 16'd2, 16'd0);
        v = idle(); v.rw_ex = 5'd7; v.wr_ex = 1'b1; v.rt_id = 5'd7;
        step(v, 1'b1, "rt_unused", ANone, 2'd0, 16'd2, 16'd0);
        v.use_rt = 1'b1;
        step(v, 1'b1, "rt_used", AStall, 2'd0, 16'd2, 16'd0);
        v.wr_ex = 1'b0;
        step(v, 1'b1, "ex_no_write", ANone, 2'd1, 16'd3, 16'd0);
`endif

        v = idle(); v.rst = 1'b1;
        step(v, 1'b1, "rst_mid", ANone, 2'd0, 16'd0, 16'd0);

        // Redirect beats a load-use hazard.
        v = idle(); v.redir = 1'b1; v.rw_ex = 5'd2; v.wr_ex = 1'b1; v.ld_ex = 1'b1;
        v.rs_id = 5'd2; v.use_rs = 1'b1;
        step(v, 1'b1, "redir_over_lu", AFlush, 2'd0, 16'd0, 16'd0);
        step(idle(), 1'b1, "after_flush", ANone, 2'd2, 16'd0, 16'd1);

        // Three-cycle freeze with a redirect pulse inside, then the deferred flush.
        v = idle(); v.busy = 1'b1; v.rw_ex = 5'd4; v.wr_ex = 1'b1; v.ld_ex = 1'b1;
        v.rs_id = 5'd4; v.use_rs = 1'b1;
        step(v, 1'b1, "busy1_over_hz", AFrz, 2'd0, 16'd0, 16'd1);
        v = idle(); v.busy = 1'b1; v.redir = 1'b1;
        step(v, 1'b1, "busy2_redir", AFrz, 2'd3, 16'd0, 16'd1);
        v.redir = 1'b0;
        step(v, 1'b1, "busy3", AFrz, 2'd3, 16'd0, 16'd1);
        step(idle(), 1'b1, "pend_flush", AFlush, 2'd3, 16'd0, 16'd1);
        step(idle(), 1'b1, "pend_done", ANone, 2'd2, 16'd0, 16'd2);
        step(idle(), 1'b1, "back_run", ANone, 2'd0, 16'd0, 16'd2);

        // Reset inside the freeze window drops the pending redirect.
        v = idle(); v.busy = 1'b1;
        step(v, 1'b1, "w_busy", AFrz, 2'd0, 16'd0, 16'd2);
        v.redir = 1'b1;
        step(v, 1'b1, "w_redir", AFrz, 2'd3, 16'd0, 16'd2);
        v.redir = 1'b0; v.rst = 1'b1;
        step(v, 1'b1, "w_rst", AFrz, 2'd0, 16'd0, 16'd0);
        step(idle(), 1'b1, "w_no_flush", ANone, 2'd0, 16'd0, 16'd0);
        step(idle(), 1'b1, "w_quiet", ANone, 2'd0, 16'd0, 16'd0);

        // Long stall run saturates the stall counter and never times out.
        hzv = idle(); hzv.rw_ex = 5'd9; hzv.wr_ex = 1'b1; hzv.ld_ex = 1'b1;
        hzv.rs_id = 5'd9; hzv.use_rs = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            step(hzv, 1'b0, "", AStall, 2'd0, 16'd0, 16'd0);
        end
        step(hzv, 1'b1, "stall_sat", AStall, 2'd1, 16'hFFFF, 16'd0);
        step(idle(), 1'b1, "sat_hold", ANone, 2'd1, 16'hFFFF, 16'd0);
        v = idle(); v.redir = 1'b1;
        step(v, 1'b1, "sat_flush", AFlush, 2'd0, 16'hFFFF, 16'd0);
        step(idle(), 1'b1, "sat_final", ANone, 2'd2, 16'hFFFF, 16'd1);

        chk_valid = 1'b0;
        #10;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports rs_id, rt_id  in  5 each  ID-stage source registers; use_rs_id, use_rt_id  in  1 each  source actually read.
REQ-004 SHALL have ports rs_ex, rt_ex  in  5 each  Ex-stage source registers (forwarding compare only).
REQ-005 SHALL have ports rw_ex, rw_mem, rw_wb  in  5 each, and regwr_ex, regwr_mem, regwr_wb  in  1 each  destination register and write-enable per stage.
REQ-006 SHALL have port memtoreg_ex  in  1  Ex-stage instruction is a load.
REQ-007 SHALL have port pc_redirect  in  1  branch/jump resolved taken in Mem stage; drives the fetch unit's PC_Src.
REQ-008 SHALL have port dmem_busy  in  1  data memory not ready this cycle.
REQ-009 SHALL have ports stall_pc, stall_if_id  out  1 each  hold PC and IF_ID; bubble_id_ex  out  1  load NOP into ID_Ex.
REQ-010 SHALL have ports flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  clear that pipeline register; freeze  out  1  hold every pipeline register and PC.
REQ-011 SHALL have ports fwd_a, fwd_b  out  2 each  Ex operand source: 00 regfile, 01 Mem-stage ALU result, 10 Wb-stage busW.
REQ-012 SHALL have ports state  out  2  FSM state; stall_cycles, flush_events  out  16 each  performance counters.

Function
REQ-013 Register 0 SHALL never create a hazard or forward match.
REQ-014 Hazard (hz) SHALL be evaluated combinationally each cycle; outputs SHALL respond in the same cycle (0-cycle latency).
REQ-015 Priority SHALL be freeze > flush > stall; only the winning action's outputs are high.
REQ-016 freeze SHALL equal dmem_busy; while high, all stall, bubble and flush outputs SHALL be 0.
REQ-017 Flush SHALL occur when !dmem_busy and (pc_redirect or pend_q): flush_if_id, flush_id_ex and flush_ex_mem all 1 for exactly that cycle.
REQ-018 pend_q SHALL set when dmem_busy and pc_redirect are both high, and SHALL clear on the cycle its flush issues.
REQ-019 Stall SHALL occur when hz, no flush and no freeze: stall_pc = stall_if_id = bubble_id_ex = 1.
REQ-020 A stall SHALL persist over as many consecutive cycles as hz holds; no counter limit applies.
REQ-021 FSM states SHALL be RUN=0, STALL=1, FLUSH=2, WAIT=3; state SHALL register the action taken in the previous cycle, or RUN if none.
REQ-022 stall_cycles SHALL increment on every stall cycle and flush_events on every flush cycle; both SHALL saturate at 0xFFFF.

Reset
REQ-023 While rst is high: state=RUN, pend_q=0, both counters 0.
REQ-024 rst asserted mid-WAIT SHALL discard any pending redirect.
REQ-025 Combinational outputs SHALL follow REQ-014..019 while in reset.

Configuration
REQ-026 With macro HAZARD_FORWARD_EN defined:
- hz = regwr_ex & memtoreg_ex & rw_ex matching a used rs_id/rt_id (load-use only, one cycle).
- fwd_a/fwd_b SHALL select 01 when the Mem stage writes rs_ex/rt_ex; else 10 when the Wb stage does; else 00. Mem wins over Wb.
REQ-027 Without the macro:
- hz = a used rs_id/rt_id matching a writing rw_ex or rw_mem (Wb excluded; the regfile writes before it reads).
- fwd_a = fwd_b = 00 at all times.

Structure
REQ-028 Package hazard_pkg SHALL hold the state encodings, the fwd encodings and counter width 16.
REQ-029 Sub-module sat_counter16 (enable, async reset, saturation) SHALL be instantiated twice.

Verification
REQ-030 lw $2 in Ex (rw_ex=2, memtoreg_ex=1), ID add reading $2, macro on -> one cycle stall_pc=stall_if_id=bubble_id_ex=1, stall_cycles=1, state=STALL the next cycle.
REQ-031 Macro off, rw_ex=3 and regwr_ex=1, then $3 moves to Mem next cycle, ID reads $3 -> 2 stall cycles, fwd_a=00.
REQ-032 Macro on, rw_mem=rw_wb=5, both writing, rs_ex=5 -> fwd_a=01; drop regwr_mem -> fwd_a=10.
REQ-033 pc_redirect=1 together with a load-use hazard -> three flushes high, stall outputs 0, flush_events +1.
REQ-034 dmem_busy=1 for 3 cycles with a 1-cycle pc_redirect pulse inside -> freeze for 3 cycles, then one flush cycle; assert rst inside the window instead -> no flush, counters 0.
REQ-035 Drive 70000 stall cycles -> stall_cycles holds at 0xFFFF.
